// File: rtl/traffic_phase_controller.sv
// Timed two-road phase sequencer with pedestrian, preempt and flash modes.
// Lamps and phase are registered from the next-state decode.
module traffic_phase_controller #(
  parameter int GREEN1_MIN = 8,
  parameter int GREEN2     = 6,
  parameter int YELLOW     = 2,
  parameter int ALLRED     = 1,
  parameter int WALK       = 4,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int M0 = (GREEN1_MIN > GREEN2) ? GREEN1_MIN : GREEN2;
  localparam int M1 = (YELLOW > ALLRED) ? YELLOW : ALLRED;
  localparam int M2 = (WALK > FLASH_HALF) ? WALK : FLASH_HALF;
  localparam int M3 = (M0 > M1) ? M0 : M1;
  localparam int MAXP = (M3 > M2) ? M3 : M2;
  localparam int TW = $clog2(MAXP + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  localparam logic [TW-1:0] L_G1   = TW'(GREEN1_MIN - 1);
  localparam logic [TW-1:0] L_G2   = TW'(GREEN2 - 1);
  localparam logic [TW-1:0] L_Y    = TW'(YELLOW - 1);
  localparam logic [TW-1:0] L_AR   = TW'(ALLRED - 1);
  localparam logic [TW-1:0] L_WALK = TW'(WALK);
  localparam logic [TW-1:0] L_TMAX = {TW{1'b1}};
  localparam logic [FW-1:0] L_FH   = FW'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    G1    = 3'd0,
    Y1    = 3'd1,
    AR1   = 3'd2,
    G2    = 3'd3,
    Y2    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [FW-1:0] r_fcnt;
  logic          r_ped;
  logic          r_grant;
  logic          r_flash;

  state_t        w_nstate;
  logic [TW-1:0] w_ntimer;
  logic [FW-1:0] w_nfcnt;
  logic          w_nped;
  logic          w_ngrant;
  logic          w_nflash;
  logic          w_serve;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      G1:    if (!s2 && r_timer >= L_G1 && (s0 || r_ped)) w_nstate = Y1;
      Y1:    if (r_timer == L_Y) w_nstate = AR1;
      AR1:   if (r_timer == L_AR) w_nstate = G2;
      G2:    if (s2 || r_timer == L_G2) w_nstate = Y2;
      Y2:    if (r_timer == L_Y) w_nstate = AR2;
      AR2:   if (r_timer == L_AR) w_nstate = G1;
      FLASH: w_nstate = AR2;
      default: w_nstate = G1;
    endcase
    if (m) w_nstate = FLASH;
  end

  always_comb begin
    w_serve  = (r_state == AR1) && (w_nstate == G2);
    w_ntimer = '0;
    if (w_nstate == r_state)
      w_ntimer = (r_timer == L_TMAX) ? r_timer : r_timer + 1'b1;
    w_nped   = w_serve ? 1'b0 : (r_ped | s1);
    w_ngrant = 1'b0;
    if (w_serve) w_ngrant = r_ped | s1;
    else if (w_nstate == G2) w_ngrant = r_grant;
    // flash starts lit and toggles every FLASH_HALF cycles
    w_nflash = 1'b0;
    w_nfcnt  = '0;
    if (w_nstate == FLASH) begin
      if (r_state != FLASH) begin
        w_nflash = 1'b1;
      end else if (r_fcnt == L_FH) begin
        w_nflash = ~r_flash;
      end else begin
        w_nflash = r_flash;
        w_nfcnt  = r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= G1;
      r_timer <= '0;
      r_fcnt  <= '0;
      r_ped   <= 1'b0;
      r_grant <= 1'b0;
      r_flash <= 1'b0;
      phase   <= 3'd0;
      {r1, y1, g1, r2, y2, g2, walk} <= 7'b0011000;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_ntimer;
      r_fcnt  <= w_nfcnt;
      r_ped   <= w_nped;
      r_grant <= w_ngrant;
      r_flash <= w_nflash;
      phase   <= w_nstate;
      {r1, y1, g1, r2, y2, g2, walk} <= 7'b0000000;
      case (w_nstate)
        G1:  {g1, r2} <= 2'b11;
        Y1:  {y1, r2} <= 2'b11;
        G2: begin
          {r1, g2} <= 2'b11;
          walk     <= w_ngrant && (w_ntimer < L_WALK);
        end
        Y2:  {r1, y2} <= 2'b11;
        FLASH: begin
          y1 <= w_nflash;
          y2 <= w_nflash;
        end
        default: {r1, r2} <= 2'b11;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller.
// Expected phase/lamp vectors are queued per cycle, then popped and compared.
module tb_traffic_phase_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m = 1'b0;
  logic s0 = 1'b0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;
  logic r1, y1, g1, r2, y2, g2, walk;
  logic [2:0] phase;
  logic [6:0] w_lv;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] lv;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] PG1 = 3'd0, PY1 = 3'd1, PAR1 = 3'd2;
  localparam logic [2:0] PG2 = 3'd3, PY2 = 3'd4, PAR2 = 3'd5;
  localparam logic [2:0] PFL = 3'd6;

  traffic_phase_controller dut (
    .clk(clk), .rst(rst), .m(m), .s0(s0), .s1(s1), .s2(s2),
    .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2),
    .walk(walk), .phase(phase)
  );

  assign w_lv = {r1, y1, g1, r2, y2, g2, walk};

  always #5 clk = ~clk;

  // {r1,y1,g1,r2,y2,g2,walk} required for a phase
  function automatic logic [6:0] lamps(logic [2:0] ph, logic fl, logic wk);
    case (ph)
      3'd0: return 7'b0011000;
      3'd1: return 7'b0101000;
      3'd2, 3'd5: return 7'b1001000;
      3'd3: return {6'b100001, wk};
      3'd4: return 7'b1000100;
      3'd6: return {1'b0, fl, 2'b00, fl, 2'b00};
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic void push(logic [2:0] ph, int n, logic wk, logic fl);
    for (int i = 0; i < n; i++) sb.push_back('{ph: ph, lv: lamps(ph, fl, wk)});
  endfunction

  task automatic drive(input logic a0, a1, a2, am);
    s0 = a0; s1 = a1; s2 = a2; m = am;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s0 = 0; s1 = 0; s2 = 0; m = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int c = 0;
    do_reset();
    push(PG1, 31, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (phase !== e.ph || w_lv !== e.lv) begin
        n_bad++;
        $display("FAIL reset_idle c=%0d phase=%0d lamps=%b required phase=%0d lamps=%b",
                 c, phase, w_lv, e.ph, e.lv);
      end
      drive(0, 0, 0, 0);
      c++;
    end
  endtask

  task automatic test_vehicle();
    exp_t e;
    int c = 0;
    do_reset();
    push(PG1, 8, 0, 0); push(PY1, 2, 0, 0); push(PAR1, 1, 0, 0);
    push(PG2, 6, 0, 0); push(PY2, 2, 0, 0); push(PAR2, 1, 0, 0);
    push(PG1, 1, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (phase !== e.ph || w_lv !== e.lv) begin
        n_bad++;
        $display("FAIL vehicle c=%0d phase=%0d lamps=%b required phase=%0d lamps=%b",
                 c, phase, w_lv, e.ph, e.lv);
      end
      drive(1, 0, 0, 0);
      c++;
    end
  endtask

  task automatic test_pedestrian();
    exp_t e;
    int c = 0;
    do_reset();
    push(PG1, 8, 0, 0); push(PY1, 2, 0, 0); push(PAR1, 1, 0, 0);
    push(PG2, 4, 1, 0); push(PG2, 2, 0, 0);
    push(PY2, 2, 0, 0); push(PAR2, 1, 0, 0);
    push(PG1, 13, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (phase !== e.ph || w_lv !== e.lv) begin
        n_bad++;
        $display("FAIL pedestrian c=%0d phase=%0d lamps=%b required phase=%0d lamps=%b",
                 c, phase, w_lv, e.ph, e.lv);
      end
      drive(0, c == 3, 0, 0);
      c++;
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    int c = 0;
    do_reset();
    push(PG1, 8, 0, 0); push(PY1, 2, 0, 0); push(PAR1, 1, 0, 0);
    push(PG2, 2, 0, 0); push(PY2, 2, 0, 0); push(PAR2, 1, 0, 0);
    push(PG1, 15, 0, 0); push(PY1, 1, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (phase !== e.ph || w_lv !== e.lv) begin
        n_bad++;
        $display("FAIL preempt c=%0d phase=%0d lamps=%b required phase=%0d lamps=%b",
                 c, phase, w_lv, e.ph, e.lv);
      end
      drive(1, 0, (c >= 12 && c < 30), 0);
      c++;
    end
  endtask

  task automatic test_flash();
    exp_t e;
    logic [5:0] pat = 6'b110011;
    int c = 0;
    do_reset();
    push(PG1, 8, 0, 0); push(PY1, 1, 0, 0);
    for (int i = 5; i >= 0; i--) push(PFL, 1, 0, pat[i]);
    push(PAR2, 1, 0, 0); push(PG1, 1, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (phase !== e.ph || w_lv !== e.lv) begin
        n_bad++;
        $display("FAIL flash c=%0d phase=%0d lamps=%b required phase=%0d lamps=%b",
                 c, phase, w_lv, e.ph, e.lv);
      end
      drive(c < 8, 0, 0, (c >= 8 && c < 14));
      c++;
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int c = 0;
    do_reset();
    push(PG1, 8, 0, 0); push(PY1, 2, 0, 0); push(PAR1, 1, 0, 0);
    push(PG2, 3, 1, 0); push(PG1, 14, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (phase !== e.ph || w_lv !== e.lv) begin
        n_bad++;
        $display("FAIL mid_reset c=%0d phase=%0d lamps=%b required phase=%0d lamps=%b",
                 c, phase, w_lv, e.ph, e.lv);
      end
      rst = (c == 13);
      drive(0, (c == 0 || c == 12), 0, 0);
      c++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vehicle();
    test_pedestrian();
    test_preempt();
    test_flash();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
